// File: rtl/hps_ext_regs.sv
//------------------------------------------------------------------------------
// hps_ext_regs : HPS EXT_BUS register file with status readback, control
//                registers with commit pulse, and a clearable event counter.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hps_ext_regs #(
  parameter logic [15:0] CMD_BASE   = 16'h00F0,
  parameter int          N_RD       = 4,
  parameter int          N_WR       = 2,
  parameter logic [15:0] CTRL_RESET = 16'h0000
) (
  input  logic                clk_sys,
  input  logic                reset,
  inout  wire  [35:0]         EXT_BUS,
  input  logic [16*N_RD-1:0]  stat_in,
  input  logic                evt_toggle,
  output logic [16*N_WR-1:0]  ctrl_out,
  output logic [N_WR-1:0]     ctrl_wr,
  output logic                ctrl_commit,
  output logic [7:0]          evt_cnt
);

  localparam logic [15:0] CMD_GET = CMD_BASE;
  localparam logic [15:0] CMD_SET = CMD_BASE + 16'd1;
  localparam logic [15:0] CMD_CLR = CMD_BASE + 16'd2;

  logic [15:0] io_dout;
  logic        dout_en;
  logic [15:0] io_din;
  logic        io_strobe;
  logic        io_enable;

  assign io_din    = EXT_BUS[31:16];
  assign io_strobe = EXT_BUS[33];
  assign io_enable = EXT_BUS[34];

  assign EXT_BUS[15:0] = io_dout;
  assign EXT_BUS[32]   = dout_en;
  assign EXT_BUS[35]   = 1'bz;

  logic [4:0]  word_cnt;
  logic [15:0] cmd;
  logic        wrote;
  logic        sync1;
  logic        sync2;
  logic        sync3;
  logic        evt_edge;
  logic        claimed;
  logic [15:0] stat_sel;

  assign evt_edge = sync2 ^ sync3;

  // 17-bit compare so a CMD_BASE near 16'hFFFF cannot wrap the claimed range.
  assign claimed = ({1'b0, io_din} >= {1'b0, CMD_BASE}) &&
                   ({1'b0, io_din} <= ({1'b0, CMD_BASE} + 17'd2));

  always_comb begin
    stat_sel = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (word_cnt == 5'(i + 1)) stat_sel = stat_in[16*i +: 16];
    end
  end

  always_ff @(posedge clk_sys) begin
    ctrl_wr     <= '0;
    ctrl_commit <= 1'b0;
    if (reset) begin
      io_dout  <= '0;
      dout_en  <= 1'b0;
      word_cnt <= '0;
      cmd      <= '0;
      wrote    <= 1'b0;
      evt_cnt  <= '0;
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      ctrl_out <= {N_WR{CTRL_RESET}};
    end else begin
      sync1 <= evt_toggle;
      sync2 <= sync1;
      sync3 <= sync2;
      if (evt_edge) evt_cnt <= evt_cnt + 8'd1;

      if (!io_enable) begin
        io_dout  <= '0;
        dout_en  <= 1'b0;
        word_cnt <= '0;
        cmd      <= '0;
        wrote    <= 1'b0;
        if (cmd == CMD_SET && wrote) ctrl_commit <= 1'b1;
      end else if (io_strobe) begin
        io_dout  <= '0;
        word_cnt <= (word_cnt == 5'd31) ? 5'd31 : word_cnt + 5'd1;
        if (word_cnt == 5'd0) begin
          cmd     <= io_din;
          dout_en <= claimed;
          // Reply carries the count as it stood before any clear below.
          if (claimed) io_dout <= {8'h00, evt_cnt};
          if (io_din == CMD_CLR) evt_cnt <= {7'd0, evt_edge};
        end else if (cmd == CMD_GET) begin
          io_dout <= stat_sel;
        end else if (cmd == CMD_SET) begin
          for (int i = 0; i < N_WR; i++) begin
            if (word_cnt == 5'(i + 1)) begin
              ctrl_out[16*i +: 16] <= io_din;
              ctrl_wr[i]           <= 1'b1;
              wrote                <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
